// File: rtl/tecmo_pkg.sv
// ---------------------------------------------------------------------------
// tecmo_pkg
// Shared types for the ROM download path into SDRAM.
//   SDRAM_AW      : width of a 16-bit-word SDRAM address
//   fifo_entry_t  : one buffered 32-bit write (word address + data)
//   drain_state_t : states of the FIFO-to-SDRAM drain machine
//   lane_expand() : turns a 4-bit byte-valid mask into a 32-bit byte mask
// ---------------------------------------------------------------------------
package tecmo_pkg;

    localparam int SDRAM_AW = 23;

    typedef struct packed {
        logic [SDRAM_AW-1:0] addr;
        logic [31:0]         data;
    } fifo_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } drain_state_t;

    // Lanes whose mask bit is clear become 8'h00 when a word is written out.
    function automatic logic [31:0] lane_expand(input logic [3:0] mask);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = {8{mask[i]}};
        end
        return result;
    endfunction

endpackage

// File: rtl/rom_write_fifo.sv
// ---------------------------------------------------------------------------
// rom_write_fifo
// Two-entry FIFO holding packed SDRAM writes between the byte packer and the
// drain machine. A push is accepted when not full, or when full but a pop
// happens in the same cycle (the freed slot is reused immediately).
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   push        : request to store push_entry
//   push_entry  : entry to store
//   pop         : discard the head entry (ignored when empty)
//   head        : oldest entry, valid when empty is low
//   full, empty : occupancy flags
//   count       : number of stored entries (0..2)
// ---------------------------------------------------------------------------
module rom_write_fifo
    import tecmo_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  fifo_entry_t push_entry,
    input  logic        pop,
    output fifo_entry_t head,
    output logic        full,
    output logic        empty,
    output logic [1:0]  count
);

    fifo_entry_t mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Storage is cleared on reset so the SDRAM address/data outputs, which
    // are driven straight from the head slot, read zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rom_download_writer.sv
// ---------------------------------------------------------------------------
// rom_download_writer
// Packs the HPS ioctl ROM download byte stream (little endian) into 32-bit
// words, buffers them in a 2-entry FIFO and writes them to SDRAM over a
// req/ack handshake. Throttles the HPS with ioctl_wait and pulses done once
// the download has finished and every word has reached SDRAM.
// Parameters:
//   ADDR_WIDTH : width of the ioctl byte address
//   SDRAM_BASE : 16-bit-word offset added to every SDRAM address
//   ROM_BYTES  : bytes at or above this address are ignored
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   ioctl_addr/data : byte address and byte of the current strobe
//   ioctl_wr        : one-cycle byte strobe
//   ioctl_download  : high for the duration of a download
//   ioctl_wait      : FIFO full, HPS must hold further strobes
//   sdram_addr/data : write address (16-bit words) and 32-bit data
//   sdram_we        : write enable, valid with sdram_req
//   sdram_req       : request, held until sdram_ack
//   sdram_ack       : one-cycle acceptance from the controller
//   busy            : download active, data buffered, or request pending
//   done            : one-cycle pulse when the download is fully written
// ---------------------------------------------------------------------------
module rom_download_writer
    import tecmo_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 20,
    parameter logic [SDRAM_AW-1:0]   SDRAM_BASE = 23'h000000,
    parameter logic [ADDR_WIDTH-1:0] ROM_BYTES  = 20'h80000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] ioctl_addr,
    input  logic [7:0]            ioctl_data,
    input  logic                  ioctl_wr,
    input  logic                  ioctl_download,
    output logic                  ioctl_wait,
    output logic [SDRAM_AW-1:0]   sdram_addr,
    output logic [31:0]           sdram_data,
    output logic                  sdram_we,
    output logic                  sdram_req,
    input  logic                  sdram_ack,
    output logic                  busy,
    output logic                  done
);

    // Byte-address word index -> SDRAM 16-bit-word address, modulo 2^23.
    function automatic logic [SDRAM_AW-1:0] word_to_sdram(input logic [ADDR_WIDTH-3:0] word);
        logic [ADDR_WIDTH-2:0] half_words;
        half_words = {word, 1'b0};
        return SDRAM_BASE + SDRAM_AW'(half_words);
    endfunction

    logic                  download_q;
    logic                  seen_download;
    logic [31:0]           pack;
    logic [3:0]            mask;
    logic [ADDR_WIDTH-3:0] cur_word;

    // Staging register: a completed or flushed word waits here for one edge
    // before entering the FIFO, giving the push one cycle after the strobe.
    logic                  stage_valid;
    fifo_entry_t           stage;

    logic                  download_rise;
    logic                  download_fall;
    logic                  strobe;
    logic                  accept;
    logic [1:0]            lane;
    logic [31:0]           pack_next;
    logic [3:0]            mask_next;
    logic                  word_done;
    logic                  flush;
    logic                  done_cond;

    fifo_entry_t           head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [1:0]            fifo_count;
    logic                  fifo_push;
    logic                  fifo_pop;

    drain_state_t          state;
    drain_state_t          state_next;

    assign download_rise = ioctl_download & ~download_q;
    assign download_fall = ~ioctl_download & download_q;
    assign strobe        = ioctl_wr & ioctl_download & (ioctl_addr < ROM_BYTES);
    assign accept        = strobe & ~fifo_full;
    assign lane          = ioctl_addr[1:0];
    assign word_done     = accept & (lane == 2'd3);
    assign flush         = download_fall & (mask != 4'b0000);

    // A new download starts from an empty pack register; the incoming byte
    // (if any on the same edge) is merged on top of that cleared state.
    always_comb begin
        pack_next = download_rise ? 32'h0 : pack;
        mask_next = download_rise ? 4'b0000 : mask;
        if (accept) begin
            pack_next[{lane, 3'b000} +: 8] = ioctl_data;
            mask_next[lane]                = 1'b1;
        end
    end

    // Done only once nothing is left anywhere in the path. Looking at
    // download_q as well keeps done from firing on the very edge where the
    // falling download creates a flush entry.
    assign done_cond = seen_download & ~ioctl_download & ~download_q &
                       fifo_empty & (state == IDLE) & ~stage_valid;

    assign fifo_push = stage_valid;

    // Byte packing, word completion, partial-word flush and completion flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            download_q    <= 1'b0;
            seen_download <= 1'b0;
            pack          <= 32'h0;
            mask          <= 4'b0000;
            cur_word      <= '0;
            stage_valid   <= 1'b0;
            stage         <= '0;
            done          <= 1'b0;
        end else begin
            download_q <= ioctl_download;

            if (accept) begin
                cur_word <= ioctl_addr[ADDR_WIDTH-1:2];
            end

            if (word_done) begin
                stage.addr  <= word_to_sdram(ioctl_addr[ADDR_WIDTH-1:2]);
                stage.data  <= pack_next & lane_expand(mask_next);
                stage_valid <= 1'b1;
                pack        <= 32'h0;
                mask        <= 4'b0000;
            end else if (flush) begin
                stage.addr  <= word_to_sdram(cur_word);
                stage.data  <= pack & lane_expand(mask);
                stage_valid <= 1'b1;
                pack        <= 32'h0;
                mask        <= 4'b0000;
            end else begin
                if (fifo_push && (!fifo_full || fifo_pop)) begin
                    stage_valid <= 1'b0;
                end
                pack <= pack_next;
                mask <= mask_next;
            end

            if (download_rise) begin
                seen_download <= 1'b1;
            end else if (done_cond) begin
                seen_download <= 1'b0;
            end
            done <= done_cond;
        end
    end

    // A strobe while ioctl_wait is high breaks the HPS protocol; the byte
    // has already been dropped above.
    strobe_while_full: assert property (@(posedge clk) disable iff (reset) !(strobe && fifo_full));

    rom_write_fifo u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry (stage),
        .pop        (fifo_pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Drain state register; reset drops an in-flight request at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Drain next-state. On ack, req stays up if another entry will be at the
    // head after the pop: either a second stored entry or one being pushed
    // from the stage on the same edge.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (sdram_ack) begin
                    fifo_pop = 1'b1;
                    if ((fifo_count > 2'd1) || stage_valid) begin
                        state_next = REQ;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sdram_req  = (state == REQ);
    assign sdram_we   = (state == REQ);
    assign sdram_addr = head.addr;
    assign sdram_data = head.data;
    assign ioctl_wait = fifo_full;
    assign busy       = download_q | ~fifo_empty | stage_valid | sdram_req;

endmodule

// File: tb/tb_rom_download_writer.sv
// ---------------------------------------------------------------------------
// tb_rom_download_writer
// Bench for rom_download_writer. Two instances: one with default parameters
// and one with SDRAM_BASE=23'h100000 / ROM_BYTES=4. use_lim selects which
// instance receives the ioctl stream and the ack responder.
// Expected SDRAM writes are queued as bytes are driven and compared when the
// selected instance's request is acknowledged.
// ---------------------------------------------------------------------------
module tb_rom_download_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        ioctl_download;
    logic        sdram_ack;
    logic        use_lim;

    logic        a_wait, a_we, a_req, a_busy, a_done;
    logic [22:0] a_addr;
    logic [31:0] a_data;
    logic        b_wait, b_we, b_req, b_busy, b_done;
    logic [22:0] b_addr;
    logic [31:0] b_data;

    logic        wait_s, we_s, req_s, busy_s, done_s;
    logic [22:0] addr_s;
    logic [31:0] data_s;

    int          test_count = 0;
    int          fail_count = 0;
    int          write_count = 0;
    int          done_count = 0;
    int          req_rise_count = 0;
    int          ack_delay = 3;
    int          ack_cnt = 0;
    logic        prev_req = 1'b0;
    logic [54:0] exp_q [$];

    always #5 clk = ~clk;

    rom_download_writer dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wr       (ioctl_wr & ~use_lim),
        .ioctl_download (ioctl_download & ~use_lim),
        .ioctl_wait     (a_wait),
        .sdram_addr     (a_addr),
        .sdram_data     (a_data),
        .sdram_we       (a_we),
        .sdram_req      (a_req),
        .sdram_ack      (sdram_ack & ~use_lim),
        .busy           (a_busy),
        .done           (a_done)
    );

    rom_download_writer #(
        .SDRAM_BASE (23'h100000),
        .ROM_BYTES  (20'd4)
    ) dut_lim (
        .clk            (clk),
        .reset          (reset),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wr       (ioctl_wr & use_lim),
        .ioctl_download (ioctl_download & use_lim),
        .ioctl_wait     (b_wait),
        .sdram_addr     (b_addr),
        .sdram_data     (b_data),
        .sdram_we       (b_we),
        .sdram_req      (b_req),
        .sdram_ack      (sdram_ack & use_lim),
        .busy           (b_busy),
        .done           (b_done)
    );

    assign wait_s = use_lim ? b_wait : a_wait;
    assign we_s   = use_lim ? b_we   : a_we;
    assign req_s  = use_lim ? b_req  : a_req;
    assign busy_s = use_lim ? b_busy : a_busy;
    assign done_s = use_lim ? b_done : a_done;
    assign addr_s = use_lim ? b_addr : a_addr;
    assign data_s = use_lim ? b_data : a_data;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Controller model: acknowledges a held request after ack_delay cycles.
    initial begin
        sdram_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            sdram_ack = 1'b0;
            if (req_s && !reset) begin
                if (ack_cnt >= ack_delay) begin
                    sdram_ack = 1'b1;
                    ack_cnt   = 0;
                end else begin
                    ack_cnt++;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    // Monitor: counts req rises and done pulses, scores each accepted write.
    always @(negedge clk) begin
        logic [54:0] e;
        if (!reset && req_s && !prev_req) req_rise_count++;
        prev_req = req_s;
        if (!reset && done_s) done_count++;
        if (!reset && req_s && sdram_ack) begin
            write_count++;
            check_output("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_output("sdram_addr", 32'(addr_s), 32'(e[54:32]));
                check_output("sdram_data", data_s, e[31:0]);
                check_output("sdram_we", 32'(we_s), 32'd1);
            end
        end
    end

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic apply_byte(input logic [19:0] addr, input logic [7:0] data);
        int guard = 0;
        while (wait_s && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 500) check_output("wait_timeout", 32'(wait_s), 32'd0);
        ioctl_addr = addr;
        ioctl_data = data;
        ioctl_wr   = 1'b1;
        @(posedge clk);
        #1;
        ioctl_wr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic start_download();
        ioctl_download = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic end_download(input string tag);
        int guard = 0;
        int base_done = done_count;
        ioctl_download = 1'b0;
        while ((exp_q.size() != 0 || done_count == base_done) && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check_output({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check_output({tag, "_done_once"}, 32'(done_count - base_done), 32'd1);
        check_output({tag, "_idle_req"}, 32'(req_s), 32'd0);
        check_output({tag, "_idle_busy"}, 32'(busy_s), 32'd0);
    endtask

    initial begin
        int          base_writes;
        int          base_rises;
        int          base_done;
        logic [31:0] d;

        reset          = 1'b0;
        ioctl_addr     = '0;
        ioctl_data     = '0;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        use_lim        = 1'b0;
        #1 reset = 1'b1;
        #1;
        check_output("rst_req",  32'(req_s),  32'd0);
        check_output("rst_we",   32'(we_s),   32'd0);
        check_output("rst_wait", 32'(wait_s), 32'd0);
        check_output("rst_busy", 32'(busy_s), 32'd0);
        check_output("rst_done", 32'(done_s), 32'd0);
        check_output("rst_addr", 32'(addr_s), 32'd0);
        check_output("rst_data", data_s,      32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Single word, ack three cycles after req.
        ack_delay   = 3;
        base_writes = write_count;
        start_download();
        check_output("single_busy", 32'(busy_s), 32'd1);
        exp_q.push_back({23'h000000, 32'h44332211});
        apply_byte(20'd0, 8'h11);
        apply_byte(20'd1, 8'h22);
        apply_byte(20'd2, 8'h33);
        apply_byte(20'd3, 8'h44);
        end_download("single");
        check_output("single_writes", 32'(write_count - base_writes), 32'd1);

        // Three words with the controller stalling 20 cycles per ack.
        ack_delay   = 20;
        base_writes = write_count;
        base_rises  = req_rise_count;
        start_download();
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 4; b++) d[8*b +: 8] = 8'h10 + 8'(4*w + b);
            exp_q.push_back({23'(2*w), d});
        end
        for (int i = 0; i < 12; i++) begin
            apply_byte(20'(i), 8'h10 + 8'(i));
            if (i == 3) check_output("b2b_wait_low_one_word", 32'(wait_s), 32'd0);
            if (i == 7) check_output("b2b_wait_high_two_words", 32'(wait_s), 32'd1);
        end
        end_download("b2b");
        check_output("b2b_writes", 32'(write_count - base_writes), 32'd3);
        check_output("b2b_req_continuous", 32'(req_rise_count - base_rises), 32'd1);

        // Partial word flushed when the download falls.
        ack_delay   = 2;
        base_writes = write_count;
        start_download();
        exp_q.push_back({23'h000000, 32'hDDCCBBAA});
        exp_q.push_back({23'h000002, 32'h0000FFEE});
        apply_byte(20'd0, 8'hAA);
        apply_byte(20'd1, 8'hBB);
        apply_byte(20'd2, 8'hCC);
        apply_byte(20'd3, 8'hDD);
        apply_byte(20'd4, 8'hEE);
        apply_byte(20'd5, 8'hFF);
        end_download("flush");
        check_output("flush_writes", 32'(write_count - base_writes), 32'd2);

        // Restart mid-word: flush, then a new download with upper lanes only.
        base_writes = write_count;
        base_done   = done_count;
        start_download();
        exp_q.push_back({23'h000000, 32'h0000BBAA});
        apply_byte(20'd0, 8'hAA);
        apply_byte(20'd1, 8'hBB);
        ioctl_download = 1'b0;
        @(posedge clk);
        #1;
        ioctl_download = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back({23'h000000, 32'hD4C30000});
        apply_byte(20'd2, 8'hC3);
        apply_byte(20'd3, 8'hD4);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check_output("restart_no_early_done", 32'(done_count - base_done), 32'd0);
        end_download("restart");
        check_output("restart_writes", 32'(write_count - base_writes), 32'd2);

        // Reset in the middle of a stalled transfer.
        ack_delay   = 1000;
        base_writes = write_count;
        start_download();
        for (int i = 0; i < 8; i++) apply_byte(20'(i), 8'h50 + 8'(i));
        check_output("midrst_pre_req", 32'(req_s), 32'd1);
        check_output("midrst_pre_wait", 32'(wait_s), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_output("midrst_req",  32'(req_s),  32'd0);
        check_output("midrst_we",   32'(we_s),   32'd0);
        check_output("midrst_wait", 32'(wait_s), 32'd0);
        check_output("midrst_busy", 32'(busy_s), 32'd0);
        check_output("midrst_done", 32'(done_s), 32'd0);
        ioctl_download = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        base_done = done_count;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check_output("midrst_no_writes", 32'(write_count - base_writes), 32'd0);
        check_output("midrst_no_done", 32'(done_count - base_done), 32'd0);

        // Limit and base offset on the second instance.
        use_lim     = 1'b1;
        ack_delay   = 2;
        base_writes = write_count;
        @(posedge clk);
        #1;
        start_download();
        exp_q.push_back({23'h100000, 32'h67452301});
        apply_byte(20'd0, 8'h01);
        apply_byte(20'd1, 8'h23);
        apply_byte(20'd2, 8'h45);
        apply_byte(20'd3, 8'h67);
        apply_byte(20'd4, 8'h89);
        apply_byte(20'd5, 8'hAB);
        apply_byte(20'd6, 8'hCD);
        apply_byte(20'd7, 8'hEF);
        end_download("limit");
        check_output("limit_writes", 32'(write_count - base_writes), 32'd1);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
